spart_bus_controller: RTL and testbench

Host-side sequencer for the SPART bus (iocs/iorw/ioaddr/databus). After reset and on any baud change, it programs the 16-bit baud divisor into the baud rate generator: low byte at ioaddr 2'b10, then high byte at 2'b11. Afterwards it arbitrates the single bus port between user transmit writes and receive reads at ioaddr 2'b00, gated by the SPART tbr/rda status lines.

---
 rtl/spart_pkg.sv | 38 +++
 rtl/spart_divisor_rom.sv | 21 ++
 rtl/spart_bus_controller.sv | 149 ++++++++++++++
 tb/tb_spart_bus_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART host-side bus sequencer: bus addresses,
// baud encoding, FSM states and the elaboration-time divisor helper.
package spart_pkg;

  localparam logic [1:0] IOADDR_BUF    = 2'b00;
  localparam logic [1:0] IOADDR_STAT   = 2'b01;
  localparam logic [1:0] IOADDR_DIV_LO = 2'b10;
  localparam logic [1:0] IOADDR_DIV_HI = 2'b11;

  typedef enum logic [1:0] {
    BAUD_4800  = 2'b00,
    BAUD_9600  = 2'b01,
    BAUD_19200 = 2'b10,
    BAUD_38400 = 2'b11
  } baud_e;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    RD_RX,
    WR_TX,
    GAP
  } state_e;

  // round(clk_hz / (16 * baud)) - 1, evaluated only with constant arguments
  function automatic logic [15:0] baud_divisor(input int unsigned clk_hz, input logic [1:0] sel);
    int unsigned baud;
    case (baud_e'(sel))
      BAUD_4800:  baud = 4800;
      BAUD_9600:  baud = 9600;
      BAUD_19200: baud = 19200;
      default:    baud = 38400;
    endcase
    return 16'((clk_hz + 8 * baud) / (16 * baud) - 1);
  endfunction

endpackage

// File: rtl/spart_divisor_rom.sv
// Baud select to 16-bit divisor lookup; every entry is a constant folded at
// elaboration so only a 4:1 mux remains in hardware.
module spart_divisor_rom
  import spart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic [1:0]  baud_sel,
  output logic [15:0] divisor
);

  logic [15:0] table_w [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_div
    localparam logic [15:0] DIV = baud_divisor(CLK_HZ, 2'(gi));
    assign table_w[gi] = DIV;
  end

  assign divisor = table_w[baud_sel];

endmodule

// File: rtl/spart_bus_controller.sv
// Host-side SPART bus sequencer: programs the baud divisor, then arbitrates
// single-cycle receive reads and transmit writes with a one-cycle gap after each.
module spart_bus_controller
  import spart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       cfg_done,
  input  logic       tbr,
  input  logic       rda,
  input  logic [7:0] data_in,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  output logic [7:0] data_out,
  output logic       data_oe
);

  state_e      state_q, state_d;
  logic [1:0]  baud_q, baud_d;
  logic        iocs_q, iocs_d;
  logic        iorw_q, iorw_d;
  logic [1:0]  ioaddr_q, ioaddr_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_oe_q, data_oe_d;
  logic        tx_ready_q, tx_ready_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        cfg_done_q, cfg_done_d;
  logic [15:0] div_w;

  spart_divisor_rom #(.CLK_HZ(CLK_HZ)) u_div_rom (
    .baud_sel (baud_q),
    .divisor  (div_w)
  );

  // state_q names the action whose bus outputs get registered on the next edge
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    iocs_d     = 1'b0;
    iorw_d     = 1'b1;
    ioaddr_d   = IOADDR_BUF;
    data_out_d = data_out_q;
    tx_ready_d = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    cfg_done_d = cfg_done_q;
    case (state_q)
      CFG_LO: begin
        iocs_d     = 1'b1;
        iorw_d     = 1'b0;
        ioaddr_d   = IOADDR_DIV_LO;
        data_out_d = div_w[7:0];
        state_d    = CFG_HI;
      end
      CFG_HI: begin
        iocs_d     = 1'b1;
        iorw_d     = 1'b0;
        ioaddr_d   = IOADDR_DIV_HI;
        data_out_d = div_w[15:8];
        state_d    = GAP;
      end
      IDLE: begin
        if (baud_sel != baud_q) begin
          baud_d     = baud_sel;
          cfg_done_d = 1'b0;
          state_d    = CFG_LO;
        end else begin
          cfg_done_d = 1'b1;
          if (rda) begin
            state_d = RD_RX;
          end else if (tx_valid && tbr) begin
            state_d = WR_TX;
          end
        end
      end
      RD_RX: begin
        iocs_d  = 1'b1;
        iorw_d  = 1'b1;
        state_d = GAP;
      end
      WR_TX: begin
        iocs_d     = 1'b1;
        iorw_d     = 1'b0;
        data_out_d = tx_data;
        tx_ready_d = 1'b1;
        state_d    = GAP;
      end
      GAP: begin
        // The read cycle is on the bus right now; capture its data at this edge
        if (iocs_q && iorw_q) begin
          rx_data_d  = data_in;
          rx_valid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = CFG_LO;
    endcase
    data_oe_d = iocs_d & ~iorw_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= CFG_LO;
      baud_q     <= baud_sel;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      ioaddr_q   <= IOADDR_BUF;
      data_out_q <= 8'h00;
      data_oe_q  <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      iocs_q     <= iocs_d;
      iorw_q     <= iorw_d;
      ioaddr_q   <= ioaddr_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      cfg_done_q <= cfg_done_d;
    end
  end

  assign iocs     = iocs_q;
  assign iorw     = iorw_q;
  assign ioaddr   = ioaddr_q;
  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign cfg_done = cfg_done_q;

endmodule

// File: tb/tb_spart_bus_controller.sv
// Directed bench for spart_bus_controller: a slot-schedule model of the bus is
// compared every cycle, and literal expectations pin the model along the way.
module tb_spart_bus_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] baud_sel;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       cfg_done;
  logic       tbr;
  logic       rda;
  logic [7:0] data_in;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] data_out;
  logic       data_oe;

  int checks = 0;
  int errors = 0;

  spart_bus_controller #(.CLK_HZ(100_000_000)) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_sel (baud_sel),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .cfg_done (cfg_done),
    .tbr      (tbr),
    .rda      (rda),
    .data_in  (data_in),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .data_out (data_out),
    .data_oe  (data_oe)
  );

  always #5 clk = ~clk;

  // ---------------- model: a schedule of bus slots, one popped per edge ----
  localparam int K_IDLE = 0, K_LO = 1, K_HI = 2, K_RD = 3, K_WR = 4, K_GAP = 5;
  typedef struct {
    int kind;
    bit cfg;
    bit rxs;
  } slot_t;

  slot_t       sched[$];
  logic [15:0] div_tab [4] = '{16'h0515, 16'h028A, 16'h0145, 16'h00A2};
  logic [1:0]  m_baud;
  bit          model_ok = 1'b0;
  logic        e_iocs, e_iorw, e_txr, e_rxv, e_cfg;
  logic [1:0]  e_addr;
  logic [7:0]  e_dout, e_rxd;

  task automatic push(input int kind, input bit cfg, input bit rxs);
    slot_t s;
    s.kind = kind;
    s.cfg  = cfg;
    s.rxs  = rxs;
    sched.push_back(s);
  endtask

  initial begin
    slot_t s;
    forever begin
      @(posedge clk);
      if (rst !== 1'b1) begin
        sched.delete();
        push(K_LO, 1'b0, 1'b0);
        push(K_HI, 1'b0, 1'b0);
        push(K_GAP, 1'b0, 1'b0);
        m_baud = baud_sel;
        e_iocs = 1'b0; e_iorw = 1'b1; e_addr = 2'b00; e_dout = 8'h00;
        e_txr = 1'b0; e_rxv = 1'b0; e_rxd = 8'h00; e_cfg = 1'b0;
      end else begin
        if (sched.size() == 0) begin
          if (baud_sel != m_baud) begin
            m_baud = baud_sel;
            push(K_IDLE, 1'b0, 1'b0);
            push(K_LO, 1'b0, 1'b0);
            push(K_HI, 1'b0, 1'b0);
            push(K_GAP, 1'b0, 1'b0);
          end else if (rda) begin
            push(K_IDLE, 1'b1, 1'b0);
            push(K_RD, 1'b1, 1'b0);
            push(K_GAP, 1'b1, 1'b1);
          end else if (tx_valid && tbr) begin
            push(K_IDLE, 1'b1, 1'b0);
            push(K_WR, 1'b1, 1'b0);
            push(K_GAP, 1'b1, 1'b0);
          end else begin
            push(K_IDLE, 1'b1, 1'b0);
          end
        end
        s = sched.pop_front();
        e_iocs = (s.kind inside {K_LO, K_HI, K_RD, K_WR});
        e_iorw = !(s.kind inside {K_LO, K_HI, K_WR});
        e_addr = (s.kind == K_LO) ? 2'b10 : (s.kind == K_HI) ? 2'b11 : 2'b00;
        if (s.kind == K_LO) e_dout = div_tab[m_baud][7:0];
        if (s.kind == K_HI) e_dout = div_tab[m_baud][15:8];
        if (s.kind == K_WR) e_dout = tx_data;
        e_txr = (s.kind == K_WR);
        e_rxv = s.rxs;
        if (s.rxs) e_rxd = data_in;
        e_cfg = s.cfg;
      end
      model_ok = 1'b1;
    end
  end

  // ---------------- every-cycle comparison against the model --------------
  initial begin
    logic [23:0] got, exp;
    forever begin
      @(negedge clk);
      if (model_ok) begin
        got = {iocs, iorw, ioaddr, data_oe, tx_ready, rx_valid, cfg_done, data_out, rx_data};
        exp = {e_iocs, e_iorw, e_addr, e_iocs & ~e_iorw, e_txr, e_rxv, e_cfg, e_dout, e_rxd};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL cycle_model t=%0t got %h exp %h", $time, got, exp);
        end
        if (iocs === 1'b1)
          $display("bus %s addr %0d data %h tx_ready %0b cfg_done %0b", iorw ? "rd" : "wr",
                   ioaddr, iorw ? data_in : data_out, tx_ready, cfg_done);
        if (rx_valid === 1'b1)
          $display("rx byte %h", rx_data);
      end
    end
  end

  // ---------------- directed stimulus with literal expectations -----------
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_access(input logic want_rd, input int budget, input string name);
    int n = 0;
    while (!(iocs === 1'b1 && iorw === want_rd) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, {15'd0, (iocs === 1'b1 && iorw === want_rd)}, 16'd1);
  endtask

  initial begin
    int txp;
    rst = 1'b0; baud_sel = 2'b01; tx_valid = 1'b0; tx_data = 8'h00;
    tbr = 1'b0; rda = 1'b0; data_in = 8'h00;
    step(3);
    chk("reset_iocs", {15'd0, iocs}, 16'd0);
    chk("reset_iorw", {15'd0, iorw}, 16'd1);
    chk("reset_cfg_done", {15'd0, cfg_done}, 16'd0);

    // divisor programming after reset at 9600
    rst = 1'b1;
    step(1);
    chk("cfg_lo_iocs", {15'd0, iocs}, 16'd1);
    chk("cfg_lo_addr", {14'd0, ioaddr}, 16'd2);
    chk("cfg_lo_data", {8'd0, data_out}, 16'h008A);
    step(1);
    chk("cfg_hi_addr", {14'd0, ioaddr}, 16'd3);
    chk("cfg_hi_data", {8'd0, data_out}, 16'h0002);
    step(2);
    chk("cfg_done_up", {15'd0, cfg_done}, 16'd1);

    // single transmit, then held tx_valid re-accepted only after the spacing
    tbr = 1'b1; tx_valid = 1'b1; tx_data = 8'h41;
    step(1);
    chk("tx_wait_ready", {15'd0, tx_ready}, 16'd0);
    step(1);
    chk("tx_ready", {15'd0, tx_ready}, 16'd1);
    chk("tx_data_out", {8'd0, data_out}, 16'h0041);
    chk("tx_addr", {14'd0, ioaddr}, 16'd0);
    chk("tx_iorw", {15'd0, iorw}, 16'd0);
    step(1);
    chk("tx_gap_ready", {15'd0, tx_ready}, 16'd0);
    step(1);
    chk("tx_hold_ready", {15'd0, tx_ready}, 16'd0);
    step(1);
    chk("tx_second_ready", {15'd0, tx_ready}, 16'd1);
    tx_valid = 1'b0;
    step(3);

    // receive, rda held through the gap
    rda = 1'b1; data_in = 8'h5A;
    step(1);
    chk("rx_wait_iocs", {15'd0, iocs}, 16'd0);
    step(1);
    chk("rx_iocs", {15'd0, iocs}, 16'd1);
    chk("rx_iorw", {15'd0, iorw}, 16'd1);
    chk("rx_oe", {15'd0, data_oe}, 16'd0);
    step(1);
    chk("rx_valid", {15'd0, rx_valid}, 16'd1);
    chk("rx_data", {8'd0, rx_data}, 16'h005A);
    chk("rx_gap_iocs", {15'd0, iocs}, 16'd0);
    rda = 1'b0;
    step(1);
    chk("rx_no_double", {15'd0, iocs}, 16'd0);
    step(1);
    chk("rx_valid_once", {15'd0, rx_valid}, 16'd0);
    step(2);

    // simultaneous rx and tx: read wins, one write follows
    rda = 1'b1; data_in = 8'hC3; tx_valid = 1'b1; tbr = 1'b1; tx_data = 8'h7E;
    wait_access(1'b1, 6, "both_read_first");
    chk("both_no_tx_yet", {15'd0, tx_ready}, 16'd0);
    rda = 1'b0;
    txp = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (i == 0) chk("both_rx_data", {8'd0, rx_data}, 16'h00C3);
      if (tx_ready === 1'b1) begin
        txp++;
        tx_valid = 1'b0;
      end
    end
    chk("both_tx_pulses", 16'(txp), 16'd1);
    step(2);

    // baud change to 38400 beats a pending write
    baud_sel = 2'b11; tx_valid = 1'b1; tx_data = 8'h55;
    step(1);
    chk("rebaud_cfg_low", {15'd0, cfg_done}, 16'd0);
    step(1);
    chk("rebaud_lo_addr", {14'd0, ioaddr}, 16'd2);
    chk("rebaud_lo_data", {8'd0, data_out}, 16'h00A2);
    step(1);
    chk("rebaud_hi_data", {8'd0, data_out}, 16'h0000);
    chk("rebaud_no_tx", {15'd0, tx_ready}, 16'd0);
    step(2);
    chk("rebaud_cfg_up", {15'd0, cfg_done}, 16'd1);
    wait_access(1'b0, 4, "rebaud_write_after");
    chk("rebaud_tx_data", {8'd0, data_out}, 16'h0055);
    tx_valid = 1'b0;
    step(3);

    // reset lands on the write edge: write aborted, reconfig restarts
    tx_valid = 1'b1; tx_data = 8'h99;
    step(1);
    rst = 1'b0;
    step(1);
    chk("rst_mid_iocs", {15'd0, iocs}, 16'd0);
    chk("rst_mid_tx_ready", {15'd0, tx_ready}, 16'd0);
    chk("rst_mid_cfg_done", {15'd0, cfg_done}, 16'd0);
    chk("rst_mid_data_out", {8'd0, data_out}, 16'h0000);
    rst = 1'b1; tx_valid = 1'b0;
    step(1);
    chk("rst_then_cfg_lo", {14'd0, ioaddr}, 16'd2);
    chk("rst_then_lo_data", {8'd0, data_out}, 16'h00A2);
    step(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
